// File: rtl/cipher_pkg.sv
// Shared constants and state encoding for the iterative Feistel cipher engine.
package cipher_pkg;

    localparam int CTRL_START      = 0;
    localparam int CTRL_CLEAR      = 1;
    localparam int CTRL_ROUNDS_LSB = 8;

    localparam int ROT_AMT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] rotl32(input logic [31:0] v);
        return (v << ROT_AMT) | (v >> (32 - ROT_AMT));
    endfunction

endpackage

// File: rtl/cipher_round_fn.sv
// One combinational Feistel round: L' = R, R' = L ^ (rotl(R,3) + rk) ^ i.
module cipher_round_fn
    import cipher_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic [31:0]      i_l,
    input  logic [31:0]      i_r,
    input  logic [31:0]      i_rk,
    input  logic [IDX_W-1:0] i_idx,
    output logic [31:0]      o_l,
    output logic [31:0]      o_r
);

    logic [31:0] w_sum;
    logic [31:0] w_f;

    assign w_sum = rotl32(i_r) + i_rk;
    assign w_f   = w_sum ^ {{(32-IDX_W){1'b0}}, i_idx};
    assign o_l   = i_r;
    assign o_r   = i_l ^ w_f;

endmodule

// File: rtl/cipher_round_engine.sv
// Iterative 64-bit Feistel engine: one round per clock, sticky done and
// a single-cycle completion interrupt.
module cipher_round_engine
    import cipher_pkg::*;
#(
    parameter int MAX_ROUNDS_LOG2 = 5
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [63:0]                key_in,
    input  logic [63:0]                plain_in,
    input  logic [31:0]                control_in,
    output logic [63:0]                cipher_out,
    output logic                       busy,
    output logic                       done,
    output logic [MAX_ROUNDS_LOG2-1:0] round_cnt,
    output logic                       irq_done
);

    localparam int NW = MAX_ROUNDS_LOG2;

    state_t r_state;
    state_t w_next;

    logic          r_start_q;
    logic [63:0]   r_key;
    logic [31:0]   r_l;
    logic [31:0]   r_r;
    logic [NW-1:0] r_n;
    logic [NW-1:0] r_cnt;
    logic [63:0]   r_cipher;
    logic          r_irq;

    logic          w_start_pulse;
    logic          w_clear;
    logic [NW-1:0] w_n_in;
    logic          w_last;
    logic [31:0]   w_rk;
    logic [31:0]   w_l_nxt;
    logic [31:0]   w_r_nxt;
    logic          w_unused_ctrl;

    assign w_start_pulse = control_in[CTRL_START] & ~r_start_q;
    assign w_clear       = control_in[CTRL_CLEAR];
    assign w_n_in        = control_in[CTRL_ROUNDS_LSB +: NW];
    assign w_last        = (r_cnt == r_n - {{(NW-1){1'b0}}, 1'b1});
    assign w_unused_ctrl = ^{control_in[31:CTRL_ROUNDS_LSB+NW],
                             control_in[CTRL_ROUNDS_LSB-1:2]};

    // Even rounds use K0 (upper word), odd rounds use K1.
    assign w_rk = r_cnt[0] ? r_key[31:0] : r_key[63:32];

    cipher_round_fn #(
        .IDX_W (NW)
    ) u_round (
        .i_l   (r_l),
        .i_r   (r_r),
        .i_rk  (w_rk),
        .i_idx (r_cnt),
        .o_l   (w_l_nxt),
        .o_r   (w_r_nxt)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start_pulse)
                    w_next = (w_n_in == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (w_last)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                if (w_start_pulse)
                    w_next = (w_n_in == '0) ? ST_DONE : ST_RUN;
                else if (w_clear)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_start_q <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_start_q <= control_in[CTRL_START];
            r_irq     <= (w_next == ST_DONE) && (r_state != ST_DONE);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_key    <= '0;
            r_l      <= '0;
            r_r      <= '0;
            r_n      <= '0;
            r_cnt    <= '0;
            r_cipher <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_pulse) begin
                        r_key <= key_in;
                        r_l   <= plain_in[63:32];
                        r_r   <= plain_in[31:0];
                        r_cnt <= '0;
                        if (w_n_in == '0)
                            r_cipher <= plain_in;
                        else
                            r_n <= w_n_in;
                    end
                end
                ST_RUN: begin
                    r_l   <= w_l_nxt;
                    r_r   <= w_r_nxt;
                    r_cnt <= r_cnt + {{(NW-1){1'b0}}, 1'b1};
                    if (w_last)
                        r_cipher <= {w_l_nxt, w_r_nxt};
                end
                default: ;
            endcase
        end
    end

    assign cipher_out = r_cipher;
    assign busy       = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign round_cnt  = r_cnt;
    assign irq_done   = r_irq;

endmodule

// File: tb/tb_cipher_round_engine.sv
// Scoreboard bench for cipher_round_engine: a reference Feistel model
// queues expected ciphertexts at start and they are compared at done.
module tb_cipher_round_engine;

    logic        clk;
    logic        rst;
    logic [63:0] key_in;
    logic [63:0] plain_in;
    logic [31:0] control_in;
    logic [63:0] cipher_out;
    logic        busy;
    logic        done;
    logic [4:0]  round_cnt;
    logic        irq_done;

    int checks = 0;
    int failures = 0;
    int irq_cnt = 0;
    logic [63:0] sb_q[$];

    cipher_round_engine #(
        .MAX_ROUNDS_LOG2 (5)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .key_in     (key_in),
        .plain_in   (plain_in),
        .control_in (control_in),
        .cipher_out (cipher_out),
        .busy       (busy),
        .done       (done),
        .round_cnt  (round_cnt),
        .irq_done   (irq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (irq_done === 1'b1) irq_cnt++;

    function automatic logic [63:0] model(input logic [63:0] k,
                                          input logic [63:0] p,
                                          input int n);
        logic [31:0] l, r, rk, t, nl;
        l = p[63:32];
        r = p[31:0];
        for (int i = 0; i < n; i++) begin
            rk = (i % 2 == 0) ? k[63:32] : k[31:0];
            t  = {r[28:0], r[31:29]} + rk;
            nl = r;
            r  = l ^ (t ^ 32'(i));
            l  = nl;
        end
        return {l, r};
    endfunction

    task automatic start_run(input logic [63:0] k, input logic [63:0] p,
                             input int n);
        key_in     = k;
        plain_in   = p;
        control_in = 32'(n) << 8 | 32'h1;
        sb_q.push_back(model(k, p, n));
    endtask

    task automatic wait_result(input int n, input int pre, input string nm);
        int cyc;
        bit seen_busy;
        logic [63:0] exp;
        cyc = pre;
        seen_busy = (pre > 0);
        do begin
            @(negedge clk);
            cyc++;
            if (busy) seen_busy = 1;
        end while (!done && cyc < 100);
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout done=%b required=1", nm, done);
        end
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
        checks++;
        if (cipher_out !== exp) begin
            failures++;
            $display("FAIL %s_cipher got=%h required=%h", nm, cipher_out, exp);
        end
        checks++;
        if (cyc != n + 1) begin
            failures++;
            $display("FAIL %s_latency got=%0d required=%0d", nm, cyc, n + 1);
        end
        checks++;
        if (round_cnt !== 5'(n)) begin
            failures++;
            $display("FAIL %s_round_cnt got=%0d required=%0d", nm, round_cnt, n);
        end
        checks++;
        if (seen_busy != (n > 0) || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy seen=%b now=%b required_seen=%b",
                     nm, seen_busy, busy, n > 0);
        end
    endtask

    task automatic clear_done();
        control_in = 32'h2;
        @(negedge clk);
        control_in = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        control_in = '0;
        key_in = '0;
        plain_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cipher_out, busy, done, round_cnt, irq_done} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%b/%0d/%b required=0",
                     cipher_out, busy, done, round_cnt, irq_done);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_round();
        int irq0;
        irq0 = irq_cnt;
        start_run(64'h0, 64'h00000000_00000001, 1);
        wait_result(1, 0, "single");
        checks++;
        if (cipher_out !== 64'h00000001_00000008) begin
            failures++;
            $display("FAIL single_const got=%h required=0000000100000008",
                     cipher_out);
        end
        control_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 1) begin
            failures++;
            $display("FAIL single_irq got=%0d required=1", irq_cnt - irq0);
        end
        clear_done();
    endtask

    task automatic test_bypass();
        start_run(64'h1234, 64'hDEADBEEF_01234567, 0);
        wait_result(0, 0, "bypass");
        control_in = '0;
        @(negedge clk);
        clear_done();
    endtask

    task automatic test_two_rounds();
        start_run(64'h00000001_00000002, 64'h00000000_00000001, 2);
        wait_result(2, 0, "two");
        checks++;
        if (cipher_out !== 64'h00000009_0000004A) begin
            failures++;
            $display("FAIL two_const got=%h required=000000090000004A",
                     cipher_out);
        end
        control_in = '0;
        @(negedge clk);
        clear_done();
    endtask

    task automatic test_start_ignored();
        start_run(64'hA5A5A5A5_5A5A5A5A, 64'h01234567_89ABCDEF, 31);
        repeat (3) @(negedge clk);
        control_in = 32'(31) << 8;
        @(negedge clk);
        control_in = 32'(31) << 8 | 32'h1;
        key_in = 64'hFFFF0000_0000FFFF;
        plain_in = 64'h0;
        wait_result(31, 4, "ignored");
        control_in = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] k, p;
        int n;
        for (int t = 0; t < 4; t++) begin
            k = {$urandom, $urandom};
            p = {$urandom, $urandom};
            n = $urandom_range(1, 12);
            start_run(k, p, n);
            wait_result(n, 0, "b2b");
            control_in = '0;
            @(negedge clk);
        end
    endtask

    task automatic test_clear_restart();
        int irq0;
        control_in = 32'h2;
        @(negedge clk);
        control_in = '0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle done=%b busy=%b required=0/0", done, busy);
        end
        rst = 1'b1;
        start_run(64'h11112222_33334444, 64'h55556666_77778888, 3);
        @(negedge clk);
        rst = 1'b0;
        irq0 = irq_cnt;
        wait_result(3, 0, "restart");
        repeat (10) @(negedge clk);
        checks++;
        if (irq_cnt - irq0 != 1 || done !== 1'b1) begin
            failures++;
            $display("FAIL restart_once irqs=%0d done=%b required=1/1",
                     irq_cnt - irq0, done);
        end
        control_in = '0;
        @(negedge clk);
        clear_done();
    endtask

    task automatic test_reset_mid_run();
        int irq0;
        start_run(64'hCAFEBABE_0BADF00D, 64'h13572468_24681357, 10);
        repeat (5) @(negedge clk);
        void'(sb_q.pop_back());
        irq0 = irq_cnt;
        rst = 1'b1;
        control_in = '0;
        @(negedge clk);
        checks++;
        if ({cipher_out, busy, done, round_cnt, irq_done} !== '0) begin
            failures++;
            $display("FAIL midrst_state got=%h/%b/%b/%0d/%b required=0",
                     cipher_out, busy, done, round_cnt, irq_done);
        end
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++;
        if (irq_cnt != irq0 || done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet irqs=%0d done=%b busy=%b required=0/0/0",
                     irq_cnt - irq0, done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_bypass();
        test_two_rounds();
        test_start_ignored();
        test_back_to_back();
        test_clear_restart();
        test_reset_mid_run();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left got=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
